// File: rtl/mem8_sram.sv
// mem8_sram: 256 x 8 synchronous single-port SRAM bank with registered read data,
// write-through on writes and a one-cycle synchronous clear of the whole array.
module mem8_sram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CEN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;
    logic              wr_en;

    // Controls are decoded as a pair so that an unknown CEN or WEN lands in the
    // default arm and drives Q to X in four-state simulation; the arm is
    // unreachable in hardware.
    always_comb begin
        q_d   = q_q;
        wr_en = 1'b0;
        case ({CEN, WEN})
            2'b00: begin
                q_d   = D;
                wr_en = 1'b1;
            end
            2'b01:   q_d = mem_q[A];
            2'b10,
            2'b11:   q_d = q_q;
            default: q_d = 'x;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            q_q <= q_d;
            if (wr_en) begin
                mem_q[A] <= D;
            end
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_mem8_sram.sv
// Directed bench for mem8_sram: each step pushes its expected Q to a queue and
// the value is popped and compared one time unit after the active edge.
module tb_mem8_sram;

    logic       CLK;
    logic       RST;
    logic       CEN;
    logic       WEN;
    logic [7:0] A;
    logic [7:0] D;
    logic [7:0] Q;

    logic [7:0] exp_q[$];
    logic [7:0] ref_mem [256];
    int         checks;
    int         errors;

    mem8_sram #(.DATA_W(8), .ADDR_W(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .CEN(CEN),
        .WEN(WEN),
        .A  (A),
        .D  (D),
        .Q  (Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_q(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, Q=%h", tag, Q);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (Q === e) else begin
                errors++;
                $error("FAIL %s: Q=%h expected %h", tag, Q, e);
            end
        end
    endtask

    // One clock step: drive on the falling edge, check just after the rising edge.
    task automatic step(input logic rst, input logic cen, input logic wen,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] e, input string tag);
        @(negedge CLK);
        RST = rst;
        CEN = cen;
        WEN = wen;
        A   = a;
        D   = d;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        check_q(tag);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rd;
        checks = 0;
        errors = 0;
        RST = 1'b1;
        CEN = 1'b1;
        WEN = 1'b1;
        A   = '0;
        D   = '0;

        step(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, "reset");
        step(1'b0, 1'b0, 1'b1, 8'h37, 8'h00, 8'h00, "read_after_reset");

        step(1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'hA5, "write_00");
        step(1'b0, 1'b0, 1'b0, 8'hFF, 8'h5A, 8'h5A, "write_ff");
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, "read_00");
        step(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h5A, "read_ff");

        step(1'b0, 1'b0, 1'b0, 8'h10, 8'h3C, 8'h3C, "write_through_10");
        step(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h3C, "read_10");

        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, "read_00_again");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hA5, "deselect_hold");
        end
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, "read_00_after_deselect");
        step(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h3C, "read_10_after_deselect");

        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'(i), 8'(i) ^ 8'hC3, 8'(i) ^ 8'hC3, "sweep_write");
        end
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(i), 8'h00, 8'(i) ^ 8'hC3, "sweep_read");
        end

        step(1'b0, 1'b0, 1'b1, 8'h55, 8'h00, 8'h55 ^ 8'hC3, "read_55");
        step(1'b1, 1'b0, 1'b0, 8'h20, 8'h77, 8'h00, "reset_mid_write");
        step(1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 8'h00, "read_20_after_reset");
        step(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, "read_ff_after_reset");
        step(1'b0, 1'b1, 1'b1, 8'h20, 8'h00, 8'h00, "idle_after_reset");

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            ref_mem[ra] = rd;
            step(1'b0, 1'b0, 1'b0, ra, rd, rd, "rand_write");
        end
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            step(1'b0, 1'b0, 1'b1, ra, 8'($urandom_range(0, 255)), ref_mem[ra], "rand_read");
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
